// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: XLEN, 2-bit counter type,
// counter state constants and the saturating counter update.
package bp_pkg;

  localparam int XLEN = 32;

  typedef logic [1:0] counter_t;

  localparam counter_t SNT = 2'b00;
  localparam counter_t WNT = 2'b01;
  localparam counter_t WT  = 2'b10;
  localparam counter_t ST  = 2'b11;

  function automatic counter_t sat_update(input counter_t cnt, input logic taken);
    counter_t res;
    res = cnt;
    case (cnt)
      SNT: res = taken ? WNT : SNT;
      WNT: res = taken ? WT  : SNT;
      WT:  res = taken ? ST  : WNT;
      ST:  res = taken ? ST  : WT;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_mispredict_check.sv
// Execute-stage mispredict detection and redirect PC selection; compares the
// resolved outcome only against the prediction carried down the pipe.
module bp_mispredict_check
  import bp_pkg::*;
#(
  parameter int XLEN = bp_pkg::XLEN
) (
  input  logic            i_upd,
  input  logic            i_taken,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_target,
  input  logic [XLEN-1:0] i_pred_target,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_redirect_pc
);

  logic w_dir_wrong;
  logic w_tgt_wrong;

  assign w_dir_wrong = i_taken != i_pred_taken;
  assign w_tgt_wrong = i_taken & i_pred_taken & (i_target != i_pred_target);

  assign o_mispredict  = i_upd & (w_dir_wrong | w_tgt_wrong);
  // Fall-through wraps modulo 2^XLEN.
  assign o_redirect_pc = i_taken ? i_target : i_pc + XLEN'(4);

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped 2-bit counter BHT with tag-less target array and execute-side
// mispredict check. Optional gshare indexing via `BP_GSHARE_EN.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int       INDEX_W   = 6,
  parameter int       XLEN      = bp_pkg::XLEN,
  parameter counter_t CNT_RESET = WNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc_f,
  output logic               pred_taken_f,
  output logic [XLEN-1:0]    pred_target_f,
  output logic [INDEX_W-1:0] pred_idx_f,
  input  logic               ex_branch,
  input  logic               ex_kill,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [INDEX_W-1:0] ex_idx,
  input  logic               ex_taken,
  input  logic [XLEN-1:0]    ex_target,
  input  logic               ex_pred_taken,
  input  logic [XLEN-1:0]    ex_pred_target,
  output logic               mispredict,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam int ENTRIES = 1 << INDEX_W;

  logic                       w_upd;
  logic [INDEX_W-1:0]         w_idx_f;
  logic                       w_unused_pc;
  counter_t [ENTRIES-1:0]     r_cnt;
  counter_t [ENTRIES-1:0]     w_cnt_next;
  logic [ENTRIES-1:0]         r_valid;
  logic [ENTRIES-1:0]         w_valid_next;
  logic [XLEN-1:0]            r_target [ENTRIES];

  assign w_upd       = ex_branch & ~ex_kill;
  assign w_unused_pc = ^{pc_f[XLEN-1:INDEX_W+2], pc_f[1:0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] r_ghr;

  // History is non-speculative: it only advances on resolved branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_upd) begin
      r_ghr <= {r_ghr[INDEX_W-2:0], ex_taken};
    end
  end

  assign w_idx_f = pc_f[INDEX_W+1:2] ^ r_ghr;
`else
  assign w_idx_f = pc_f[INDEX_W+1:2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic w_hit;
      assign w_hit            = w_upd && (ex_idx == INDEX_W'(gi));
      assign w_cnt_next[gi]   = w_hit ? sat_update(r_cnt[gi], ex_taken) : r_cnt[gi];
      // A not-taken resolve never invalidates a learned target.
      assign w_valid_next[gi] = r_valid[gi] | (w_hit & ex_taken);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= {ENTRIES{CNT_RESET}};
      r_valid <= '0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_valid <= w_valid_next;
    end
  end

  // Targets are guarded by r_valid, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_upd && ex_taken) begin
      r_target[ex_idx] <= ex_target;
    end
  end

  // Lookup reads current state only; a same-cycle update is not bypassed.
  assign pred_idx_f    = w_idx_f;
  assign pred_taken_f  = r_valid[w_idx_f] & r_cnt[w_idx_f][1];
  assign pred_target_f = r_target[w_idx_f];

  bp_mispredict_check #(
    .XLEN(XLEN)
  ) u_check (
    .i_upd         (w_upd),
    .i_taken       (ex_taken),
    .i_pred_taken  (ex_pred_taken),
    .i_target      (ex_target),
    .i_pred_target (ex_pred_target),
    .i_pc          (ex_pc),
    .o_mispredict  (mispredict),
    .o_redirect_pc (redirect_pc)
  );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht (default and
// BP_GSHARE_EN builds); expected values are hand-computed per vector.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic [5:0]  pred_idx_f;
  logic        ex_branch;
  logic        ex_kill;
  logic [31:0] ex_pc;
  logic [5:0]  ex_idx;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int         vec_count   = 0;
  int         miscompares = 0;
  logic [5:0] tb_ghr      = '0;

  branch_predictor_bht dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_f           (pc_f),
    .pred_taken_f   (pred_taken_f),
    .pred_target_f  (pred_target_f),
    .pred_idx_f     (pred_idx_f),
    .ex_branch      (ex_branch),
    .ex_kill        (ex_kill),
    .ex_pc          (ex_pc),
    .ex_idx         (ex_idx),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Fetch PC that lands on table entry idx given the current history.
  function automatic logic [31:0] pc_for(input logic [5:0] idx);
`ifdef BP_GSHARE_EN
    return 32'h100 | {24'h0, idx ^ tb_ghr, 2'b00};
`else
    return 32'h100 | {24'h0, idx, 2'b00};
`endif
  endfunction

  task automatic clear_ex();
    ex_branch = 0; ex_kill = 0; ex_pc = 0; ex_idx = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic resolve(input logic [5:0] idx, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt, input logic [31:0] pc);
    ex_branch = 1; ex_kill = 0; ex_idx = idx; ex_taken = taken; ex_target = tgt;
    ex_pred_taken = ptaken; ex_pred_target = ptgt; ex_pc = pc;
  endtask

  task automatic step();
    if (ex_branch && !ex_kill) tb_ghr = {tb_ghr[4:0], ex_taken};
    @(posedge clk);
    #1;
    clear_ex();
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_ex();
    pc_f = 32'h100;
    @(posedge clk);
    #1;
    rst_n = 1;
    tb_ghr = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_ex();
    pc_f = 32'h100;
    #2;
    vec_count++;
    if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL reset_pred pred_taken_f=%b expected=0", pred_taken_f); end
    else $display("ok reset_pred");
    vec_count++;
    if (pred_idx_f !== 6'h00) begin miscompares++; $display("FAIL reset_idx pred_idx_f=%h expected=00", pred_idx_f); end
    else $display("ok reset_idx");
    vec_count++;
    if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_misp mispredict=%b expected=0", mispredict); end
    else $display("ok reset_misp");
    pc_f = 32'h1FC;
    #1;
    vec_count++;
    if (pred_idx_f !== 6'h3F || pred_taken_f !== 1'b0) begin
      miscompares++; $display("FAIL reset_idx_hi idx=%h taken=%b expected idx=3f taken=0", pred_idx_f, pred_taken_f);
    end else $display("ok reset_idx_hi");
    @(posedge clk);
    #1;
    rst_n = 1;
    tb_ghr = '0;
  endtask

  task automatic test_first_taken();
    do_reset();
    pc_f = pc_for(6'd0);
    resolve(6'd0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h100);
    #1;
    vec_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      miscompares++; $display("FAIL first_misp misp=%b redir=%h expected 1/00000080", mispredict, redirect_pc);
    end else $display("ok first_misp");
    vec_count++;
    if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL no_bypass pred_taken_f=%b expected=0", pred_taken_f); end
    else $display("ok no_bypass");
    step();
    pc_f = pc_for(6'd0);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h80 || pred_idx_f !== 6'd0) begin
      miscompares++; $display("FAIL first_learn taken=%b tgt=%h idx=%h expected 1/00000080/00", pred_taken_f, pred_target_f, pred_idx_f);
    end else $display("ok first_learn");
  endtask

  task automatic test_saturation();
    bit t_seq [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    bit p_seq [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      resolve(6'd5, t_seq[i], 32'h500, t_seq[i], 32'h500, 32'h514);
      #1;
      vec_count++;
      if (mispredict !== 1'b0) begin miscompares++; $display("FAIL sat_misp[%0d] mispredict=%b expected=0", i, mispredict); end
      step();
      pc_f = pc_for(6'd5);
      #1;
      vec_count++;
      if (pred_taken_f !== p_seq[i] || pred_idx_f !== 6'd5) begin
        miscompares++; $display("FAIL sat_pred[%0d] taken=%b idx=%h expected %b/05", i, pred_taken_f, pred_idx_f, p_seq[i]);
      end else $display("ok sat_pred[%0d] taken=%b", i, pred_taken_f);
    end
  endtask

  task automatic test_target_change();
    do_reset();
    resolve(6'd9, 1'b1, 32'h200, 1'b0, 32'h0, 32'h900);
    step();
    resolve(6'd9, 1'b1, 32'h204, 1'b1, 32'h200, 32'h900);
    #1;
    vec_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin
      miscompares++; $display("FAIL tgt_misp misp=%b redir=%h expected 1/00000204", mispredict, redirect_pc);
    end else $display("ok tgt_misp");
    step();
    pc_f = pc_for(6'd9);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h204) begin
      miscompares++; $display("FAIL tgt_update taken=%b tgt=%h expected 1/00000204", pred_taken_f, pred_target_f);
    end else $display("ok tgt_update");
    resolve(6'd9, 1'b1, 32'h204, 1'b1, 32'h204, 32'h900);
    #1;
    vec_count++;
    if (mispredict !== 1'b0) begin miscompares++; $display("FAIL tgt_match mispredict=%b expected=0", mispredict); end
    else $display("ok tgt_match");
    resolve(6'd9, 1'b0, 32'h204, 1'b0, 32'h300, 32'h900);
    #1;
    vec_count++;
    if (mispredict !== 1'b0) begin miscompares++; $display("FAIL nt_match mispredict=%b expected=0", mispredict); end
    else $display("ok nt_match");
    resolve(6'd9, 1'b0, 32'h204, 1'b1, 32'h204, 32'h900);
    #1;
    vec_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h904) begin
      miscompares++; $display("FAIL nt_misp misp=%b redir=%h expected 1/00000904", mispredict, redirect_pc);
    end else $display("ok nt_misp");
    step();
  endtask

  task automatic test_kill();
    do_reset();
    pc_f = pc_for(6'd12);
    resolve(6'd12, 1'b1, 32'h300, 1'b0, 32'h0, 32'hC00);
    ex_kill = 1;
    #1;
    vec_count++;
    if (mispredict !== 1'b0) begin miscompares++; $display("FAIL kill_misp mispredict=%b expected=0", mispredict); end
    else $display("ok kill_misp");
    step();
    pc_f = pc_for(6'd12);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL kill_table pred_taken_f=%b expected=0", pred_taken_f); end
    else $display("ok kill_table");
    resolve(6'd12, 1'b1, 32'h300, 1'b0, 32'h0, 32'hC00);
    ex_branch = 0;
    #1;
    vec_count++;
    if (mispredict !== 1'b0) begin miscompares++; $display("FAIL nobranch_misp mispredict=%b expected=0", mispredict); end
    else $display("ok nobranch_misp");
    step();
    pc_f = pc_for(6'd12);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL nobranch_table pred_taken_f=%b expected=0", pred_taken_f); end
    else $display("ok nobranch_table");
  endtask

  task automatic test_wrap();
    do_reset();
    resolve(6'd3, 1'b0, 32'h0, 1'b1, 32'h40, 32'hFFFF_FFFC);
    #1;
    vec_count++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      miscompares++; $display("FAIL wrap misp=%b redir=%h expected 1/00000000", mispredict, redirect_pc);
    end else $display("ok wrap");
    ex_pc = 32'h1000;
    #1;
    vec_count++;
    if (redirect_pc !== 32'h1004) begin miscompares++; $display("FAIL fallthru redir=%h expected=00001004", redirect_pc); end
    else $display("ok fallthru");
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    resolve(6'd20, 1'b1, 32'h2000, 1'b0, 32'h0, 32'h50);
    step();
    resolve(6'd21, 1'b1, 32'h2100, 1'b0, 32'h0, 32'h54);
    step();
    pc_f = pc_for(6'd20);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h2000) begin
      miscompares++; $display("FAIL b2b_20 taken=%b tgt=%h expected 1/00002000", pred_taken_f, pred_target_f);
    end else $display("ok b2b_20");
    pc_f = pc_for(6'd21);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h2100) begin
      miscompares++; $display("FAIL b2b_21 taken=%b tgt=%h expected 1/00002100", pred_taken_f, pred_target_f);
    end else $display("ok b2b_21");
    pc_f = pc_for(6'd22);
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL b2b_22 pred_taken_f=%b expected=0", pred_taken_f); end
    else $display("ok b2b_22");
    // Asynchronous reset between clock edges must clear the table at once.
    pc_f = pc_for(6'd20);
    rst_n = 0;
    #1;
    vec_count++;
    if (pred_taken_f !== 1'b0) begin miscompares++; $display("FAIL async_rst pred_taken_f=%b expected=0", pred_taken_f); end
    else $display("ok async_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    tb_ghr = '0;
  endtask

  task automatic test_gshare();
    logic [5:0] exp_idx;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      resolve(6'd0, 1'b1, 32'h80, 1'b1, 32'h80, 32'h100);
      step();
    end
    pc_f = 32'h100;
`ifdef BP_GSHARE_EN
    exp_idx = 6'h07;
`else
    exp_idx = 6'h00;
`endif
    #1;
    vec_count++;
    if (pred_idx_f !== exp_idx) begin miscompares++; $display("FAIL ghr_idx pred_idx_f=%h expected=%h", pred_idx_f, exp_idx); end
    else $display("ok ghr_idx idx=%h", pred_idx_f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_taken();
    test_saturation();
    test_target_change();
    test_kill();
    test_wrap();
    test_back_to_back();
    test_gshare();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
